// File: rtl/pe_output_drain_if.sv
// Output BRAM write bus driven by the PE output drain.
// One write per cycle, no backpressure.
interface pe_output_drain_if #(
    parameter int DW     = 16,
    parameter int ADDR_W = 10
);
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DW-1:0]     bram_din;

    modport master (
        output bram_we,
        output bram_addr,
        output bram_din
    );

    modport slave (
        input bram_we,
        input bram_addr,
        input bram_din
    );
endinterface

// File: rtl/pe_output_drain.sv
// Drains output-stationary PE psums out of the chain tail
// into output BRAM in PE-index order, with optional ReLU.
module pe_output_drain #(
    parameter int DW     = 16,
    parameter int N_PE   = 16,
    parameter int ADDR_W = 10,
    localparam int CW    = $clog2(N_PE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CW-1:0]     pe_count,
    input  logic              relu_en,
    input  logic              clear_after,
    input  logic [DW-1:0]     chain_tail_in,
    output logic              output_eject_ctrl,
    output logic              en_out,
    output logic              clear_psum,
    output logic              busy,
    output logic              done,
    pe_output_drain_if.master bram
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              relu_q, relu_d;
    logic              clr_q, clr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     din_q, din_d;
    logic [CW-1:0]     offset;
    logic [CW-1:0]     eff_len;

    // Words leave the tail highest index first, so the
    // address counts down from base+len-1 to base.
    always_comb begin
        offset = len_q - cnt_q - CW'(1);
        eff_len = pe_count;
        if (pe_count == '0 || pe_count > CW'(N_PE)) begin
            eff_len = CW'(N_PE);
        end
    end

    // Next-state, capture and chain control.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        len_d             = len_q;
        base_d            = base_q;
        relu_d            = relu_q;
        clr_d             = clr_q;
        we_d              = 1'b0;
        addr_d            = addr_q;
        din_d             = din_q;
        output_eject_ctrl = 1'b0;
        en_out            = 1'b0;
        clear_psum        = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = eff_len;
                    base_d  = base_addr;
                    relu_d  = relu_en;
                    clr_d   = clear_after;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                output_eject_ctrl = 1'b1;
                en_out            = 1'b1;
                busy              = 1'b1;
                state_d           = S_SHIFT;
            end
            S_SHIFT: begin
                en_out = 1'b1;
                busy   = 1'b1;
                // Psums are already in the output registers,
                // so the accumulators may be cleared now.
                clear_psum = clr_q && (cnt_q == '0);
                we_d   = 1'b1;
                addr_d = base_q + ADDR_W'(offset);
                din_d  = (relu_q && chain_tail_in[DW-1])
                         ? '0 : chain_tail_in;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == len_q - CW'(1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched config and registered BRAM write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            relu_q  <= 1'b0;
            clr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            base_q  <= base_d;
            relu_q  <= relu_d;
            clr_q   <= clr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign bram.bram_we   = we_q;
    assign bram.bram_addr = addr_q;
    assign bram.bram_din  = din_q;

endmodule

// File: tb/tb_pe_output_drain.sv
// Randomized scoreboard bench for pe_output_drain with a
// behavioural 4-PE chain model driving chain_tail_in.
module tb_pe_output_drain;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] pe_count = '0;
    logic          relu_en = 1'b0;
    logic          clear_after = 1'b0;
    logic [DW-1:0] chain_tail_in;
    logic          output_eject_ctrl;
    logic          en_out;
    logic          clear_psum;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pe_output_drain_if #(.DW(DW), .ADDR_W(AW)) bif ();

    pe_output_drain #(
        .DW(DW), .N_PE(N), .ADDR_W(AW)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_addr         (base_addr),
        .pe_count          (pe_count),
        .relu_en           (relu_en),
        .clear_after       (clear_after),
        .chain_tail_in     (chain_tail_in),
        .output_eject_ctrl (output_eject_ctrl),
        .en_out            (en_out),
        .clear_psum        (clear_psum),
        .busy              (busy),
        .done              (done),
        .bram              (bif)
    );

    // PE column model: psum accumulators and output chain.
    logic signed [DW-1:0] psum     [N];
    logic signed [DW-1:0] oreg     [N];
    logic signed [DW-1:0] psum_src [N];
    logic                 psum_wr = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (psum_wr) psum[i] <= psum_src[i];
            else if (clear_psum) psum[i] <= '0;
            if (en_out) begin
                if (output_eject_ctrl) oreg[i] <= psum[i];
                else if (i == 0) oreg[i] <= '0;
                else oreg[i] <= oreg[i-1];
            end
        end
    end

    assign chain_tail_in = oreg[N-1];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  passed = 0;
    int  total = 0;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    // Monitor: every BRAM write must match the next expectation.
    always @(negedge clk) begin
        if (bif.bram_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bif.bram_addr), 32'(mon_e.a));
                check("wr_data", 32'(bif.bram_din), 32'(mon_e.d));
            end
        end
    end

    function automatic int eff(logic [CW-1:0] pc);
        if (pc == 0 || pc > N) return N;
        return int'(pc);
    endfunction

    // Reference: PE[N-1-k] lands at base+C-1-k, k = 0..C-1.
    task automatic push_expected(logic [AW-1:0] base,
                                 logic [CW-1:0] pc,
                                 logic relu, int limit);
        int  c;
        wr_t e;
        c = eff(pc);
        for (int k = 0; k < c && k < limit; k++) begin
            e.a = AW'((int'(base) + c - 1 - k) % (1 << AW));
            if (relu && psum_src[N-1-k] < 0) e.d = '0;
            else e.d = psum_src[N-1-k];
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {busy, done, output_eject_ctrl,
                en_out, clear_psum, bif.bram_we};
    endfunction

    function automatic logic [5:0] ctl_exp(int k, int c,
                                           logic clr);
        logic [5:0] v;
        v[5] = (k >= 1 && k <= c + 2);
        v[4] = (k == c + 3);
        v[3] = (k == 1);
        v[2] = (k >= 1 && k <= c + 1);
        v[1] = clr && (k == 2);
        v[0] = (k >= 3 && k <= c + 2);
        return v;
    endfunction

    task automatic issue(logic [AW-1:0] base,
                         logic [CW-1:0] pc,
                         logic relu, logic clr);
        @(negedge clk);
        base_addr   = base;
        pe_count    = pc;
        relu_en     = relu;
        clear_after = clr;
        psum_wr     = 1'b1;
        start       = 1'b1;
    endtask

    task automatic run_drain(logic [AW-1:0] base,
                             logic [CW-1:0] pc,
                             logic relu, logic clr,
                             logic sid);
        int c;
        c = eff(pc);
        issue(base, pc, relu, clr);
        push_expected(base, pc, relu, N);
        for (int k = 1; k <= c + 5; k++) begin
            @(negedge clk);
            psum_wr = 1'b0;
            start   = sid && (k == c + 3);
            check($sformatf("ctl_cyc%0d", k),
                  32'(ctl()), 32'(ctl_exp(k, c, clr)));
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            check($sformatf("psum%0d", i), 32'(psum[i]),
                  clr ? 32'd0 : 32'(psum_src[i]));
        end
    endtask

    task automatic load_fixed();
        psum_src[0] = 16'sd10;
        psum_src[1] = -16'sd20;
        psum_src[2] = 16'sd30;
        psum_src[3] = -16'sd40;
    endtask

    initial begin
        load_fixed();
        repeat (3) @(negedge clk);
        check("reset_ctl", 32'(ctl()), 32'd0);
        check("reset_addr", 32'(bif.bram_addr), 32'd0);
        check("reset_din", 32'(bif.bram_din), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_drain(10'd100, 3'd0, 1'b0, 1'b0, 1'b0);
        run_drain(10'd100, 3'd0, 1'b1, 1'b0, 1'b1);
        run_drain(10'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        run_drain(10'd1022, 3'd4, 1'b0, 1'b0, 1'b0);
        run_drain(10'd5, 3'd7, 1'b0, 1'b1, 1'b0);

        // Abort: second start at cycle 3, reset in cycle 4.
        issue(10'd200, 3'd4, 1'b0, 1'b0);
        push_expected(10'd200, 3'd4, 1'b0, 1);
        @(negedge clk);
        psum_wr = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_cyc3", 32'(ctl()),
              32'(ctl_exp(3, 4, 1'b0)));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_ctl", 32'(ctl()), 32'd0);
        check("abort_addr", 32'(bif.bram_addr), 32'd0);
        check("abort_din", 32'(bif.bram_din), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_hold", 32'(ctl()), 32'd0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_idle", 32'(ctl()), 32'd0);
        end
        check("abort_queue", exp_q.size(), 0);
        exp_q.delete();
        run_drain(10'd300, 3'd0, 1'b1, 1'b1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                psum_src[i] = DW'($urandom);
            end
            run_drain(AW'($urandom_range(0, 1023)),
                      CW'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom),
                      1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pe_output_drain.md
Name: pe_output_drain

Overview:
- Read-side counterpart of the PE output ejection chain. The chain is a column of output-stationary PEs linked output_out to output_in.
- The block commands the column to latch its partial sums, shifts them out of the tail PE one word per cycle, and writes them into output BRAM in PE-index order.
- Optional ReLU is applied on write. It also issues the post-drain psum clear so the next tile can start accumulating.

Parameters:
- DW, 16, data width of PE outputs and BRAM words (signed fixed-point).
- N_PE, 16, number of PEs in the drained chain.
- ADDR_W, 10, output BRAM address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; requests a drain. Sampled only in IDLE.
- base_addr  input  ADDR_W  BRAM address for PE index 0. Latched on start.
- pe_count  input  $clog2(N_PE+1)  number of words to drain from the tail. 0 or >N_PE is treated as N_PE. Latched on start.
- relu_en  input  1  1 = negative words written as 0. Latched on start.
- clear_after  input  1  1 = pulse clear_psum after capture. Latched on start.
- chain_tail_in  input  DW  output_out of the tail PE (PE index N_PE-1).
- output_eject_ctrl  output  1  to all PEs; 1 = load own psum into output register.
- en_out  output  1  to all PEs; output register update enable.
- clear_psum  output  1  to all PEs; clear accumulator.
- bram_we  output  1  BRAM write enable.
- bram_addr  output  ADDR_W  BRAM write address.
- bram_din  output  DW  BRAM write data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when drain completes.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. Counters, latched config and write register cleared. Reset mid-drain aborts immediately; no further BRAM writes occur.
- Chain semantics:
  - en_out=1 with output_eject_ctrl=1: each PE loads its psum.
  - en_out=1 with output_eject_ctrl=0: each PE loads output_in, shifting toward the tail.
  - chain_tail_in is the tail register value, valid combinationally.
- FSM states: IDLE, LOAD, SHIFT, FLUSH, DONE.
- IDLE: on start=1, latch config, set cnt=0, go to LOAD. start in any other state is ignored.
- LOAD (1 cycle): output_eject_ctrl=1, en_out=1. Next state is SHIFT.
- SHIFT (C cycles, C = effective pe_count), each cycle:
  - Capture chain_tail_in into the write register.
  - Set wr_addr = base + (C-1-cnt), modulo 2^ADDR_W with wrap silently allowed.
  - en_out=1, output_eject_ctrl=0.
  - clear_psum=1 in the first SHIFT cycle only, if clear_after is set.
  - cnt++.
  - When cnt==C-1, go to FLUSH.
- Writes are registered. bram_we=1 in the cycle after each capture, with bram_addr and bram_din from the write register. bram_din = (relu && word<0) ? 0 : word, with no other arithmetic.
- FLUSH (1 cycle): last write issued. en_out=0. Next state is DONE.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE. A start arriving in DONE is ignored.
- Timing, start accepted at edge 0:
  - LOAD is cycle 1.
  - SHIFT is cycles 2..C+1.
  - bram_we is high for cycles 3..C+2, contiguous.
  - done is in cycle C+3.
  - busy is high for cycles 1..C+2.
- Ordering: first captured word is PE[N_PE-1] and goes to base+C-1. Last captured word is PE[N_PE-C] and goes to base. With C=N_PE, address base+i holds PE[i].
- No backpressure: BRAM accepts one write per cycle.
- output_eject_ctrl and clear_psum are never high in the same cycle.

Test Plan:
- N_PE=4, psums {10,-20,30,-40} for PE0..3, base=100, pe_count=0, relu=0 -> four writes on consecutive cycles: (103,-40),(102,30),(101,-20),(100,10). done in cycle 7 after start; busy high in cycles 1..6.
- Same psums with relu=1 -> writes (103,0),(102,30),(101,0),(100,10).
- pe_count=2, base=0 -> exactly 2 writes: (1,-40),(0,30). done in cycle 5. No further bram_we.
- base=1022, ADDR_W=10, pe_count=4 -> addresses 1,0,1023,1022 (wrap).
- clear_after=1 -> clear_psum high only in cycle 2. Never coincides with output_eject_ctrl=1 (cycle 1).
- Second start pulse at cycle 3 is ignored. rst=0 at cycle 4 -> all outputs 0 at once, no later bram_we. A fresh start after release drains correctly.
